custom_axi_ip_regs: RTL
=======================

Name: custom_axi_ip_regs

Overview:
- AXI4-Lite subordinate register front-end for the custom_axi_ip core.
- Terminates AXI4-Lite from the system interconnect. Drives the core's register-to-hardware inputs (data word and start pulse) and captures its outputs (result data, valid, status) into software-readable registers.
- Adds a sticky done flag and a done-event counter so software can poll without racing the core's one-cycle result pulse.

Parameters:
- DATA_WIDTH, 32, AXI data width; only 32 is supported.
- ADDR_WIDTH, 5, AXI address width; byte addresses 0x00–0x1C are decoded.

Ports:
- clk_i  input  1  clock; all logic on rising edge
- rst_ni  input  1  reset, asynchronous assert, active-low
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  write address channel
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write data channel
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  read address channel
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data channel
- hw_din_o  output  16  data word to core din
- hw_enable_o  output  1  start pulse to core enable_in
- hw_dout_i  input  16  core result dout
- hw_valid_i  input  2  core enable_out; bit0 = result valid
- hw_status_i  input  2  core status_out, mirrored raw

Behaviour:
- Reset (rst_ni low, async): all ready/valid outputs 0; bresp/rresp 0; s_rdata 0; hw_din_o 0; hw_enable_o 0; all registers 0.
- Register map (word-aligned, addr[1:0] ignored):
  - 0x00 CTRL: bit0 START is write-1-to-pulse and reads 0.
  - 0x04 DIN: [15:0] RW, byte-lane masked by wstrb[1:0].
  - 0x08 DOUT: [15:0] RO.
  - 0x0C STATUS: [1:0] hw_status_i live; bit8 DONE sticky, W1C.
  - 0x10 COUNT: [15:0] done-event count; any write with wstrb != 0 clears it.
  - Unused bits read 0.
- Write handshake:
  - s_awready and s_wready assert together for exactly one cycle when s_awvalid && s_wvalid && !s_bvalid.
  - Register update happens on that accept edge.
  - s_bvalid asserts the next cycle and holds with stable s_bresp until s_bready.
  - No new write is accepted while s_bvalid=1.
- Read handshake:
  - s_arready asserts for one cycle when s_arvalid && !s_rvalid.
  - s_rdata/s_rresp are registered and s_rvalid asserts the next cycle, holding until s_rready.
- Response codes:
  - Addresses 0x14–0x1C: write has no effect with bresp=SLVERR (2'b10); read returns rdata=0 with rresp=SLVERR. All others return OKAY.
  - Writes to DOUT are OKAY and have no effect.
- Start pulse:
  - A CTRL write with wdata[0]=1 and wstrb[0]=1 drives hw_enable_o=1 for exactly one cycle, the cycle after accept.
  - If the same beat could also update DIN it cannot, because the addresses differ. DIN is always stable before START when software writes DIN first.
- Result capture:
  - On any cycle with hw_valid_i[0]=1: DOUT <= hw_dout_i, DONE <= 1, COUNT <= COUNT+1.
  - COUNT wraps 0xFFFF -> 0x0000.
- Simultaneous events:
  - Capture and DONE W1C on the same edge: set wins, DONE=1.
  - Capture and COUNT clear on the same edge: COUNT=1.
  - Read of DOUT on the same edge as capture returns the pre-capture value.
- Channel independence: read and write paths are independent and may complete in the same cycle.
- Reset mid-transaction: all pending responses are dropped; valids are 0 after reset release.

Test Plan:
- Write DIN=0x00001234 (wstrb=0xF), then read 0x04 -> bresp=OKAY; rdata=0x00001234; hw_din_o=0x1234.
- Write DIN=0xABCD with wstrb=0x2 over 0x1234 -> DIN=0xAB34.
- Write CTRL=0x1 -> hw_enable_o high exactly one cycle, the cycle after accept. CTRL reads 0x0.
- Drive hw_valid_i=2'b01 with hw_dout_i=0x1235 for one cycle, then read 0x08/0x0C/0x10 -> 0x1235; bit8=1; 0x1.
- Write STATUS=0x100 on the same cycle as another hw_valid_i pulse -> DONE stays 1 and COUNT=2. A later W1C with no pulse -> DONE=0.
- Preload COUNT at 0xFFFF via pulses, then apply one more pulse -> COUNT=0x0000.
- Read 0x14 and write 0x18 -> rresp/bresp=SLVERR, rdata=0.
- Hold s_bready=0 for 5 cycles -> bvalid held, a second write is not accepted until s_bready.
- Assert rst_ni low mid-read -> rvalid=0 immediately.

Source files
------------

// File: rtl/custom_axi_ip_regs.sv
// rtl/custom_axi_ip_regs.sv - AXI4-Lite register front-end for the custom_axi_ip core
module custom_axi_ip_regs #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic [15:0]             hw_din_o,
   output logic                    hw_enable_o,
   input  logic [15:0]             hw_dout_i,
   input  logic [1:0]              hw_valid_i,
   input  logic [1:0]              hw_status_i
);

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_DIN    = 3'd1;
   localparam logic [2:0] A_DOUT   = 3'd2;
   localparam logic [2:0] A_STATUS = 3'd3;
   localparam logic [2:0] A_COUNT  = 3'd4;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                  aw_rdy_q;
   logic                  ar_rdy_q;
   logic                  wr_en;
   logic                  rd_en;
   logic [2:0]            wr_idx;
   logic [2:0]            rd_idx;
   logic                  wr_err;
   logic                  rd_err;
   logic                  capture;
   logic [15:0]           din_q;
   logic [15:0]           dout_q;
   logic [15:0]           count_q;
   logic                  done_q;
   logic [DATA_WIDTH-1:0] rd_mux;
   logic                  unused_bits;

   assign wr_idx    = s_awaddr[4:2];
   assign rd_idx    = s_araddr[4:2];
   assign wr_err    = (wr_idx > A_COUNT);
   assign rd_err    = (rd_idx > A_COUNT);
   assign s_awready = aw_rdy_q;
   assign s_wready  = aw_rdy_q;
   assign s_arready = ar_rdy_q;
   assign wr_en     = aw_rdy_q & s_awvalid & s_wvalid;
   assign rd_en     = ar_rdy_q & s_arvalid;
   assign capture   = hw_valid_i[0];
   assign hw_din_o  = din_q;

   assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0], s_wdata[DATA_WIDTH-1:16], hw_valid_i[1]};

   // Ready is a one-cycle registered pulse; the edge that ends it is the accept edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         aw_rdy_q <= 1'b0;
         s_bvalid <= 1'b0;
         s_bresp  <= RESP_OKAY;
      end else begin
         aw_rdy_q <= s_awvalid && s_wvalid && !s_bvalid && !aw_rdy_q;
         if (wr_en) begin
            s_bvalid <= 1'b1;
            s_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else if (s_bready) begin
            s_bvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      case (rd_idx)
         A_DIN:    rd_mux[15:0] = din_q;
         A_DOUT:   rd_mux[15:0] = dout_q;
         A_STATUS: begin
            rd_mux[1:0] = hw_status_i;
            rd_mux[8]   = done_q;
         end
         A_COUNT:  rd_mux[15:0] = count_q;
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ar_rdy_q <= 1'b0;
         s_rvalid <= 1'b0;
         s_rresp  <= RESP_OKAY;
         s_rdata  <= '0;
      end else begin
         ar_rdy_q <= s_arvalid && !s_rvalid && !ar_rdy_q;
         if (rd_en) begin
            s_rvalid <= 1'b1;
            s_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            s_rdata  <= rd_mux;
         end else if (s_rready) begin
            s_rvalid <= 1'b0;
         end
      end
   end

   // Capture has priority over software clears so no done event is ever lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         din_q       <= '0;
         dout_q      <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         hw_enable_o <= 1'b0;
      end else begin
         hw_enable_o <= wr_en && (wr_idx == A_CTRL) && s_wstrb[0] && s_wdata[0];
         if (wr_en && (wr_idx == A_DIN)) begin
            if (s_wstrb[0]) din_q[7:0]  <= s_wdata[7:0];
            if (s_wstrb[1]) din_q[15:8] <= s_wdata[15:8];
         end
         if (capture) begin
            dout_q <= hw_dout_i;
         end
         if (capture) begin
            done_q <= 1'b1;
         end else if (wr_en && (wr_idx == A_STATUS) && s_wstrb[1] && s_wdata[8]) begin
            done_q <= 1'b0;
         end
         if (wr_en && (wr_idx == A_COUNT) && (s_wstrb != '0)) begin
            count_q <= {15'd0, capture};
         end else if (capture) begin
            count_q <= count_q + 16'd1;
         end
      end
   end

endmodule
